nh_window_gen: RTL and testbench
================================

NH_WINDOW_GEN -- requirements
Module: nh_window_gen

Interface
REQ-001 Parameter PIX_W, default 24: bit width of one pixel or neighbourhood element.
REQ-002 Parameter NH_DIM, default 3: window edge length; legal range 2..7.
REQ-003 Parameter IMG_W, default 64: pixels per image line; legal range NH_DIM..4096.
REQ-004 Parameter IMG_H, default 64: lines per frame; legal range NH_DIM..4096.
REQ-005 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port shift_in_rdy, input, 1: shift_in carries a valid pixel this cycle.
REQ-008 Port shift_in, input, PIX_W: pixel data in raster order.
REQ-009 Port sof, input, 1: qualified by shift_in_rdy; marks the pixel as frame position (0,0).
REQ-010 Port shift_in_ack, output, 1: block accepts a pixel this cycle.
REQ-011 Port out_ready, input, 1: downstream consumes current_nh this cycle.
REQ-012 Port dval, output, 1: current_nh holds a valid window.
REQ-013 Port current_nh, output, PIX_W*NH_DIM*NH_DIM: window; element (r,c) occupies bits [(r*NH_DIM+c)*PIX_W +: PIX_W].
REQ-014 Port frame_done, output, 1: one-cycle pulse when the last pixel of a frame (IMG_H-1, IMG_W-1) is accepted.

Function
REQ-015 shift_in_ack = !dval || out_ready; a pixel is accepted when shift_in_rdy && shift_in_ack.
REQ-016 Nothing advances in a cycle with no accepted pixel: counters, line buffers, window and frame_done all hold.
REQ-017 Column counter col: 0..IMG_W-1, increments per accepted pixel, wraps to 0 after IMG_W-1. Row counter row: increments on that wrap, wraps to 0 after IMG_H-1.
REQ-018 On an accepted pixel with sof=1, the pixel is treated as (0,0). Counters then advance from (0,0). Line buffer contents are not cleared.
REQ-019 The block holds NH_DIM-1 line buffers of depth IMG_W. Each accepted pixel is written at address col into buffer 0, and the value read from buffer k at col is written into buffer k+1.
REQ-020 Window r = NH_DIM-1 holds the newest line; r = 0 holds the line NH_DIM-1 rows earlier; c = NH_DIM-1 holds the newest column.
REQ-021 On acceptance at (row,col), each window row shifts one column toward c=0 and takes its new c=NH_DIM-1 element from the pixel or the matching line buffer output.
REQ-022 Latency is one cycle: current_nh and dval update on the clock edge that accepts the pixel.
REQ-023 The accepted pixel at (row,col) produces dval=1 on the next cycle iff row >= NH_DIM-1 and col >= NH_DIM-1 (subject to REQ-030). Otherwise dval is cleared, unless REQ-024 holds it.
REQ-024 While dval=1 and out_ready=0, current_nh and dval hold and shift_in_ack=0 (full stall). dval is never dropped without out_ready.
REQ-025 dval=1 with out_ready=1 and shift_in_rdy=0 clears dval on the next cycle.
REQ-026 Windows never span a line wrap: after wrap-around, no dval is produced until col reaches NH_DIM-1 again.
REQ-027 frame_done is registered, asserted on the cycle after the final pixel is accepted, and lasts exactly one cycle.

Reset
REQ-028 While reset=0: dval=0, frame_done=0, current_nh=0, col=0, row=0, window registers=0. Line buffer RAM content is unspecified.
REQ-029 Reset asserted mid-frame aborts the frame. After release, the first accepted pixel is (0,0) whether or not sof is asserted.

Configuration
REQ-030 Macro NH_STRIDE2_EN: when defined, the REQ-023 condition additionally requires (row-(NH_DIM-1)) and (col-(NH_DIM-1)) both even. Windows are produced at stride 2, and the window and line buffer still shift on every accepted pixel. When undefined, stride is 1.

Verification
REQ-031 NH_DIM=3, IMG_W=IMG_H=4, pixel value row*16+col streamed without stall -> exactly 4 dval windows. The first, after pixel (2,2), has elements r0: 0x00,0x01,0x02; r1: 0x10,0x11,0x12; r2: 0x20,0x21,0x22.
REQ-032 Same setup, out_ready=0 for 5 cycles while dval=1 -> current_nh stable, shift_in_ack=0, no pixel lost; the window sequence is identical to REQ-031.
REQ-033 Frame end of REQ-031 -> frame_done high for exactly one cycle after pixel (3,3); the next frame's first window again appears after (2,2).
REQ-034 sof asserted on the 7th pixel of a frame -> counters restart at (0,0); the next dval follows the 11th pixel counted from the sof pixel.
REQ-035 reset pulsed low after 9 accepted pixels -> dval=0 and current_nh=0 immediately; a following full 4x4 frame gives the REQ-031 result.
REQ-036 With NH_STRIDE2_EN and IMG_W=IMG_H=5 -> 4 windows, at (2,2), (2,4), (4,2), (4,4). Without NH_STRIDE2_EN -> 9 windows.

Source files
------------

// File: rtl/nh_window_gen.sv
// nh_window_gen: raster pixel stream to NH_DIM x NH_DIM neighbourhood windows with one-cycle latency.
// Define NH_STRIDE2_EN to emit windows only at even offsets (stride 2); default is stride 1.
module nh_window_gen #(
    parameter int PIX_W  = 24,
    parameter int NH_DIM = 3,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             shift_in_rdy,
    input  logic [PIX_W-1:0]                 shift_in,
    input  logic                             sof,
    output logic                             shift_in_ack,
    input  logic                             out_ready,
    output logic                             dval,
    output logic [PIX_W*NH_DIM*NH_DIM-1:0]   current_nh,
    output logic                             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int N  = NH_DIM - 1;
    logic [CW-1:0]    col, pc;
    logic [RW-1:0]    row, pr;
    logic [PIX_W-1:0] lb  [N][IMG_W];
    logic [PIX_W-1:0] win [NH_DIM][NH_DIM];
    logic [PIX_W-1:0] tap [NH_DIM];
    logic             accept, last_col, last_row, hit;

    assign shift_in_ack = !dval || out_ready;
    assign accept       = shift_in_rdy && shift_in_ack;
    // sof relabels the incoming pixel as (0,0) before any decision is taken
    assign pc           = sof ? '0 : col;
    assign pr           = sof ? '0 : row;
    assign last_col     = pc == CW'(IMG_W - 1);
    assign last_row     = pr == RW'(IMG_H - 1);
`ifdef NH_STRIDE2_EN
    assign hit = pc >= CW'(N) && pr >= RW'(N) && pc[0] == 1'(N) && pr[0] == 1'(N);
`else
    assign hit = pc >= CW'(N) && pr >= RW'(N);
`endif

    always_comb begin
        tap[N] = shift_in;
        for (int r = 0; r < N; r++) tap[r] = lb[N-1-r][pc];
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            lb[0][pc] <= shift_in;
            for (int k = 1; k < N; k++) lb[k][pc] <= lb[k-1][pc];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            dval       <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < NH_DIM; r++)
                for (int c = 0; c < NH_DIM; c++) win[r][c] <= '0;
        end else begin
            frame_done <= accept && last_col && last_row;
            dval       <= accept ? hit : dval && !out_ready;
            if (accept) begin
                col <= last_col ? '0 : pc + 1'b1;
                row <= last_col ? (last_row ? '0 : pr + 1'b1) : pr;
                for (int r = 0; r < NH_DIM; r++) begin
                    for (int c = 0; c < N; c++) win[r][c] <= win[r][c+1];
                    win[r][N] <= tap[r];
                end
            end
        end
    end

    for (genvar r = 0; r < NH_DIM; r++) begin : g_r
        for (genvar c = 0; c < NH_DIM; c++) begin : g_c
            assign current_nh[(r*NH_DIM+c)*PIX_W +: PIX_W] = win[r][c];
        end
    end
endmodule

// File: tb/tb_nh_window_gen.sv
// tb_nh_window_gen: scoreboard bench for nh_window_gen on a 4x4 frame with a 3x3 window.
module tb_nh_window_gen;
    localparam int P = 8, D = 3, IW = 4, IH = 4, WB = P*D*D;
`ifdef NH_STRIDE2_EN
    localparam int WPF = 1;
`else
    localparam int WPF = 4;
`endif
    localparam logic [WB-1:0] FIRST = 72'h22_21_20_12_11_10_02_01_00;

    logic          clock = 0, reset = 1, shift_in_rdy = 0, sof = 0, out_ready = 1;
    logic [P-1:0]  shift_in = '0;
    logic          shift_in_ack, dval, frame_done;
    logic [WB-1:0] current_nh;
    logic          acc_pending = 0, win_pending = 0, last_pending = 0;
    logic [WB-1:0] exp_q [$];
    logic [P-1:0]  img [IH][IW];
    int            mr = 0, mc = 0, checks = 0, errors = 0, nwin = 0;

    nh_window_gen #(.PIX_W(P), .NH_DIM(D), .IMG_W(IW), .IMG_H(IH)) dut (
        .clock(clock), .reset(reset), .shift_in_rdy(shift_in_rdy), .shift_in(shift_in),
        .sof(sof), .shift_in_ack(shift_in_ack), .out_ready(out_ready), .dval(dval),
        .current_nh(current_nh), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        logic a, w, l;
        a = acc_pending;
        w = win_pending;
        l = last_pending;
        #1;
        chk("frame_done", {71'b0, frame_done}, {71'b0, a && l});
        if (a) begin
            chk("dval", {71'b0, dval}, {71'b0, w});
            if (w && exp_q.size() > 0) begin
                chk("window", current_nh, exp_q.pop_front());
                nwin++;
            end
        end
    end

    task automatic send(input logic [P-1:0] v, input logic s);
        int n = 0;
        logic [WB-1:0] e;
        @(negedge clock);
        shift_in_rdy = 1;
        shift_in = v;
        sof = s;
        while (!shift_in_ack && n < 50) begin
            acc_pending = 0;
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("ack_timeout", 72'd0, 72'd1);
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        win_pending = mr >= D-1 && mc >= D-1;
`ifdef NH_STRIDE2_EN
        win_pending = win_pending && (mr-(D-1)) % 2 == 0 && (mc-(D-1)) % 2 == 0;
`endif
        last_pending = mr == IH-1 && mc == IW-1;
        if (win_pending) begin
            e = '0;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) e[(r*D+c)*P +: P] = img[mr-(D-1)+r][mc-(D-1)+c];
            exp_q.push_back(e);
        end
        acc_pending = 1;
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr = (mr == IH-1) ? 0 : mr + 1;
        end
    endtask

    task automatic idle();
        @(negedge clock);
        shift_in_rdy = 0;
        sof = 0;
        acc_pending = 0;
    endtask

    task automatic stall();
        logic [WB-1:0] snap;
        @(negedge clock);
        acc_pending = 0;
        shift_in_rdy = 1;
        shift_in = 8'hEE;
        sof = 1;
        out_ready = 0;
        snap = current_nh;
        chk("stall_dval", {71'b0, dval}, 72'd1);
        repeat (5) begin
            @(negedge clock);
            chk("stall_ack", {71'b0, shift_in_ack}, 72'd0);
            chk("stall_nh", current_nh, snap);
        end
        out_ready = 1;
        shift_in_rdy = 0;
        sof = 0;
    endtask

    task automatic frame(input logic [P-1:0] salt, input int stall_at, input int chk_at);
        for (int i = 0; i < IW*IH; i++) begin
            send(P'(salt + (i/IW)*16 + i%IW), i == 0);
            if (i == chk_at) begin
                @(posedge clock);
                #1;
                chk("first_window", current_nh, FIRST);
            end
            if (i == stall_at) stall();
        end
    endtask

    task automatic finish_frame(input string tag, input int n0);
        idle();
        idle();
        chk("dval_cleared", {71'b0, dval}, 72'd0);
        chk(tag, 72'(nwin - n0), 72'(WPF));
    endtask

    initial begin
        int n0;
        #2 reset = 0;
        #1;
        chk("rst_dval", {71'b0, dval}, 72'd0);
        chk("rst_nh", current_nh, 72'd0);
        chk("rst_fd", {71'b0, frame_done}, 72'd0);
        chk("rst_ack", {71'b0, shift_in_ack}, 72'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        n0 = nwin;
        frame(8'h00, -1, 10);
        finish_frame("windows_plain", n0);
        n0 = nwin;
        frame(8'h40, 10, -1);
        finish_frame("windows_stall", n0);
        n0 = nwin;
        for (int i = 0; i < 6; i++) send(P'(8'h80 + i), i == 0);
        frame(8'h05, -1, -1);
        finish_frame("windows_sof", n0);
        for (int i = 0; i < 9; i++) send(P'(8'h30 + i), i == 0);
        idle();
        reset = 0;
        #1;
        chk("mid_rst_dval", {71'b0, dval}, 72'd0);
        chk("mid_rst_nh", current_nh, 72'd0);
        mr = 0;
        mc = 0;
        @(negedge clock);
        reset = 1;
        n0 = nwin;
        for (int i = 0; i < IW*IH; i++) send(P'((i/IW)*16 + i%IW), 1'b0);
        finish_frame("windows_after_rst", n0);
        chk("queue_empty", 72'(exp_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
